// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline stage register with valid/ready handshake,
// a 2-entry skid buffer and synchronous flush. in_ready is a flop, so there is
// no combinational path from out_ready back to in_ready.
// Optional feature macro: PIPE_STAGE_PERF_EN adds the stall_cnt/bubble_cnt
// saturating performance counters and their ports.
module pipe_stage_skid #(
    parameter int                 DATA_W    = 84,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    // EMPTY: main_v=0. FULL: main_v=1, skid_v=0. SKID: both valid.
    // Holding the occupancy as one enum makes "skid valid, main empty" unrepresentable.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic main_v;
    logic skid_v;
    logic accept;
    logic drain;

    // Degenerate widths would silently produce an unusable stage.
    if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_skid: DATA_W and CNT_W must be at least 1");
    end

    assign main_v    = (state_q != EMPTY);
    assign skid_v    = (state_q == SKID);
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    // Empty slots always hold NOP_VALUE, so no output mux is needed.
    assign out_data  = main_data_q;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Next-state and next-payload logic; flush overrides any handshake.
    always_comb begin
        // NOTE: every signal driven here gets its hold value first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_data_d = in_data;
                    state_d     = FULL;
                end
            end
            FULL: begin
                if (drain && accept) begin
                    main_data_d = in_data;
                end else if (drain) begin
                    main_data_d = NOP_VALUE;
                    state_d     = EMPTY;
                end else if (accept) begin
                    skid_data_d = in_data;
                    state_d     = SKID;
                end
            end
            SKID: begin
                // in_ready is low here, so in_data is never looked at.
                if (drain) begin
                    main_data_d = skid_data_q;
                    skid_data_d = NOP_VALUE;
                    state_d     = FULL;
                end
            end
            default: begin
                state_d     = EMPTY;
                main_data_d = NOP_VALUE;
                skid_data_d = NOP_VALUE;
            end
        endcase

        // A handshake in the flush cycle is killed along with the held entries.
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = NOP_VALUE;
            skid_data_d = NOP_VALUE;
        end
    end

    // Occupancy and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of block evaluation order.
        if (rst) begin
            // NOTE: payload registers are reset (not just the valid bits) so
            // out_data shows NOP_VALUE, never X, from the first post-reset cycle.
            state_q     <= EMPTY;
            main_data_q <= NOP_VALUE;
            skid_data_q <= NOP_VALUE;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; a flush cycle counts by its pre-edge outputs.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Counter registers: cleared only by reset, never by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a scoreboard queue receives every
// accepted payload and is popped on every drain; directed checks cover reset,
// streaming, skid, flush, drain-to-empty and (with PIPE_STAGE_PERF_EN) counters.
module tb_pipe_stage_skid;

    localparam int                DATA_W    = 84;
    localparam logic [DATA_W-1:0] NOP_VALUE = 84'h0_0000_0000_0000_0000_DEAD;
    localparam int                CNT_W     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] sb_q[$];

    pipe_stage_skid #(
        .DATA_W    (DATA_W),
        .NOP_VALUE (NOP_VALUE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard, sampled mid-cycle: pop on drain, push on accept; reset or
    // flush kills every held entry and any same-cycle handshake.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (!out_valid) begin
                check("nop_idle", out_data, NOP_VALUE);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", out_data, NOP_VALUE ^ 1);
                end else begin
                    check("sb_order", out_data, sb_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'h ABC;
        out_ready = 1'b0;

        // Reset with stimulus present.
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  NOP_VALUE);
        check("rst_in_ready",  in_ready,  1'b1);
        rst     = 1'b0;
        in_data = 'h123;
        step();
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1'b1);
        check("post_rst_data",  out_data,  'h123);
        out_ready = 1'b1;
        step();
        check("post_rst_drained", out_valid, 1'b0);

        // Streaming at one item per cycle.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            step();
            check("stream_data",     out_data,  DATA_W'(i));
            check("stream_in_ready", in_ready,  1'b1);
        end
        in_valid = 1'b0;
        step();
        check("stream_empty", out_valid, 1'b0);

        // Skid: A held by stall, B captured into skid, C waits upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'h11;
        step();
        in_data = 'h22;
        step();
        check("skid_in_ready", in_ready, 1'b0);
        check("skid_head",     out_data, 'h11);
        in_data = 'h33;
        step();
        check("skid_hold_ready", in_ready, 1'b0);
        check("skid_hold_head",  out_data, 'h11);
        out_ready = 1'b1;
        step();
        check("skid_b_out",      out_data, 'h22);
        check("skid_ready_back", in_ready, 1'b1);
        step();
        check("skid_c_out", out_data, 'h33);
        in_valid = 1'b0;
        step();
        check("skid_empty", out_valid, 1'b0);

        // Flush while in SKID with a coincident offered payload.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'h11;
        step();
        in_data = 'h22;
        step();
        check("pre_flush_ready", in_ready, 1'b0);
        flush   = 1'b1;
        in_data = 'h44;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        check("flush_data",  out_data,  NOP_VALUE);
        check("flush_ready", in_ready,  1'b1);
        out_ready = 1'b1;
        repeat (3) step();
        check("flush_no_44", out_valid, 1'b0);

        // Single item drains to empty.
        in_valid = 1'b1;
        in_data  = 'h55;
        step();
        in_valid = 1'b0;
        check("single_valid", out_valid, 1'b1);
        check("single_data",  out_data,  'h55);
        step();
        check("single_gone_valid", out_valid, 1'b0);
        check("single_gone_data",  out_data,  NOP_VALUE);

        // Random traffic with occasional flush; the scoreboard checks order.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = {$urandom, $urandom, $urandom};
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("sb_drained", 128'(sb_q.size()), 128'd0);
        check("final_empty", out_valid, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
        // Counters: saturation, flush immunity, reset clear.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("perf_rst_stall", stall_cnt, '0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'h77;
        step();
        in_valid = 1'b0;
        check("perf_bubble_one", bubble_cnt, CNT_W'(1));
        repeat (20) step();
        check("perf_stall_sat", stall_cnt, {CNT_W{1'b1}});
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("perf_flush_keeps", stall_cnt, {CNT_W{1'b1}});
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("perf_rst_clear_stall",  stall_cnt,  '0);
        check("perf_rst_clear_bubble", bubble_cnt, '0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
